// File: rtl/rom_fifo_loader.sv
// rom_fifo_loader: clears the downstream FIFO, then streams ROM words into it
// lane by lane, honouring full backpressure and waiting for write acks.
module rom_fifo_loader #(
    parameter int ROM_DATA_W  = 16,
    parameter int FIFO_DATA_W = 8,
    parameter int ADDR_W      = 8,
    parameter int ROM_LATENCY = 1,
    parameter int CLR_CYCLES  = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W-1:0]      n_words,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [FIFO_DATA_W-1:0] fifo_data_out,
    output logic                   fifo_wr_en,
    output logic                   fifo_ext_reset,
    input  logic                   fifo_full,
    input  logic                   fifo_write_ack,
    input  logic                   fifo_overflow,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [ROM_DATA_W-1:0]  rom_data
);

    localparam int LANES = ROM_DATA_W / FIFO_DATA_W;
    localparam logic [2:0] LANE_LAST = 3'(LANES - 1);
    localparam logic [2:0] WAIT_LAST = 3'(ROM_LATENCY);
    localparam logic [3:0] CLR_LAST  = 4'(CLR_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_ROM,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_words;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic [ROM_DATA_W-1:0] r_shift;
    logic [2:0]            r_lane;
    logic [2:0]            r_wait;
    logic [3:0]            r_clr;
    logic [2:0]            r_pending;
    logic                  r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        busy           = 1'b1;
        done           = 1'b0;
        fifo_ext_reset = 1'b0;
        fifo_wr_en     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fifo_ext_reset = 1'b1;
                if (r_clr == CLR_LAST) begin
                    w_next = (r_words == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (r_wait == WAIT_LAST) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // Gate on full so a write is never issued into a full FIFO
                fifo_wr_en = ~fifo_full;
                if (~fifo_full && (r_lane == LANE_LAST)) begin
                    w_next = (r_words == ONE) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (r_pending == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (fifo_overflow && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_next = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_words    <= '0;
            r_rom_addr <= '0;
            r_shift    <= '0;
            r_lane     <= '0;
            r_wait     <= '0;
            r_clr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_words <= n_words;
                        r_clr   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr <= r_clr + 4'd1;
                end
                S_FETCH: begin
                    r_rom_addr <= r_addr;
                    r_wait     <= '0;
                end
                S_WAIT_ROM: begin
                    r_wait <= r_wait + 3'd1;
                    if (r_wait == WAIT_LAST) begin
                        r_shift <= rom_data;
                        r_lane  <= '0;
                    end
                end
                S_WRITE: begin
                    if (fifo_wr_en) begin
                        r_lane  <= r_lane + 3'd1;
                        r_shift <= MSB_FIRST ? (r_shift << FIFO_DATA_W)
                                             : (r_shift >> FIFO_DATA_W);
                        if (r_lane == LANE_LAST) begin
                            r_words <= r_words - ONE;
                            r_addr  <= r_addr + ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outstanding writes; acks seen while idle are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_error   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_pending <= '0;
            if (start) begin
                r_error <= 1'b0;
            end
        end else begin
            if (fifo_overflow) begin
                r_error <= 1'b1;
            end
            unique case ({fifo_wr_en, fifo_write_ack})
                2'b10: r_pending <= r_pending + 3'd1;
                2'b01: begin
                    if (r_pending != '0) begin
                        r_pending <= r_pending - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign error         = r_error;
    assign rom_addr      = r_rom_addr;
    assign fifo_data_out = MSB_FIRST ? r_shift[ROM_DATA_W-1 -: FIFO_DATA_W]
                                     : r_shift[FIFO_DATA_W-1:0];

endmodule

// File: tb/tb_rom_fifo_loader.sv
// Bench for rom_fifo_loader: two instances (MSB-first and LSB-first lanes)
// driven by a shared stimulus and checked against a write-list model.
module tb_rom_fifo_loader;

    localparam int RW    = 16;
    localparam int FW    = 8;
    localparam int LAT   = 1;
    localparam int CLR   = 2;
    localparam int LANES = RW / FW;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] n_words = '0;
    logic full = 1'b0;
    logic ovf = 1'b0;

    logic a_busy, a_done, a_err, a_wr, a_xrst, a_ack;
    logic b_busy, b_done, b_err, b_wr, b_xrst, b_ack;
    logic [7:0] a_dout, a_addr, b_dout, b_addr;
    logic [15:0] a_rdata, b_rdata;

    logic [15:0] rom_mem [256];
    logic [3:0] a_pipe, b_pipe;
    int ack_dly = 1;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    logic [7:0] logA[$], logB[$], expA[$], expB[$];
    int clr_cnt, done_cnt, done_cyc, last_ack_cyc, bad_full, desync;

    always #5 clk = ~clk;

    rom_fifo_loader #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .n_words(n_words),
        .busy(a_busy), .done(a_done), .error(a_err),
        .fifo_data_out(a_dout), .fifo_wr_en(a_wr),
        .fifo_ext_reset(a_xrst), .fifo_full(full),
        .fifo_write_ack(a_ack), .fifo_overflow(ovf),
        .rom_addr(a_addr), .rom_data(a_rdata)
    );

    rom_fifo_loader #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .n_words(n_words),
        .busy(b_busy), .done(b_done), .error(b_err),
        .fifo_data_out(b_dout), .fifo_wr_en(b_wr),
        .fifo_ext_reset(b_xrst), .fifo_full(full),
        .fifo_write_ack(b_ack), .fifo_overflow(ovf),
        .rom_addr(b_addr), .rom_data(b_rdata)
    );

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) begin
        a_rdata <= rom_mem[a_addr];
        b_rdata <= rom_mem[b_addr];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_pipe <= '0;
            b_pipe <= '0;
        end else begin
            a_pipe <= {a_pipe[2:0], a_wr};
            b_pipe <= {b_pipe[2:0], b_wr};
        end
    end
    assign a_ack = a_pipe[ack_dly-1];
    assign b_ack = b_pipe[ack_dly-1];

    always @(negedge clk) begin
        cyc++;
        if (a_wr) logA.push_back(a_dout);
        if (b_wr) logB.push_back(b_dout);
        if (a_xrst) clr_cnt++;
        if (a_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (a_ack) last_ack_cyc = cyc;
        if ((a_wr || b_wr) && full) bad_full++;
        if ((a_wr != b_wr) || (a_done != b_done) || (a_xrst != b_xrst)) desync++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build_exp(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] a;
        logic [15:0] w;
        expA.delete();
        expB.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            w = rom_mem[a];
            for (int l = 0; l < LANES; l++) begin
                expA.push_back(w[RW-1-FW*l -: FW]);
                expB.push_back(w[FW*l +: FW]);
            end
        end
    endtask

    task automatic cmp_log(input string nm, input bit lsb, input int nexp);
        int bad;
        logic [7:0] g, e;
        int sz;
        bad = -1;
        g = '0;
        e = '0;
        sz = lsb ? logB.size() : logA.size();
        checks++;
        if (sz != nexp) begin
            errors++;
            $display("FAIL %s: %0d writes, expected %0d", nm, sz, nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                g = lsb ? logB[i] : logA[i];
                e = lsb ? expB[i] : expA[i];
                if (g !== e) begin
                    bad = i;
                    break;
                end
            end
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s: write %0d got %0h expected %0h", nm, bad, g, e);
            end
        end
    endtask

    task automatic run_load(input logic [7:0] b, input logic [7:0] n,
                            input int stall_at, input int stall_len,
                            input int ovf_at, input bit spur, input bit rfull,
                            output int lat);
        int t0, k, stall_left;
        bit stalled, ovfd;
        logA.delete();
        logB.delete();
        clr_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_ack_cyc = 0;
        bad_full = 0;
        desync = 0;
        @(posedge clk); #1;
        base_addr = b;
        n_words = n;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'h80;
        n_words = 8'h05;
        k = 0;
        stalled = 1'b0;
        ovfd = 1'b0;
        stall_left = 0;
        while (done_cnt == 0 && k < LIMIT) begin
            ovf = 1'b0;
            start = (spur && k == 3);
            if (!stalled && stall_at >= 0 && logA.size() == stall_at) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                full = 1'b1;
                stall_left--;
            end else begin
                full = rfull ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (!ovfd && ovf_at >= 0 && logA.size() == ovf_at) begin
                ovf = 1'b1;
                ovfd = 1'b1;
            end
            @(posedge clk); #1;
            k++;
            if (ovf) begin
                chk("ovf_wr_next", {62'd0, a_wr, b_wr}, 64'd0);
                chk("ovf_done_next", a_done, 1);
            end
        end
        if (k >= LIMIT) begin
            errors++;
            $display("FAIL load_timeout: no done within %0d cycles", LIMIT);
        end
        full = 1'b0;
        ovf = 1'b0;
        start = 1'b0;
        lat = done_cyc - t0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] n;
        int stall_at;
        int stall_len;
        int ovf_at;
        bit spur;
        int exp_wr;
        bit exp_err;
    } vec_t;

    vec_t vt[7];
    logic [7:0] lit0[6];
    logic [7:0] lit2[4];

    initial begin
        int lat, lat0, nw, n;
        logic [7:0] addr_before, b;

        vt[0] = '{8'h10, 8'd3, -1, 0, -1, 1'b0, 6, 1'b0};
        vt[1] = '{8'h10, 8'd3, 1, 5, -1, 1'b0, 6, 1'b0};
        vt[2] = '{8'hFF, 8'd2, -1, 0, -1, 1'b0, 4, 1'b0};
        vt[3] = '{8'h40, 8'd0, -1, 0, -1, 1'b0, 0, 1'b0};
        vt[4] = '{8'h10, 8'd3, -1, 0, 3, 1'b0, 4, 1'b1};
        vt[5] = '{8'h10, 8'd4, -1, 0, -1, 1'b0, 8, 1'b0};
        vt[6] = '{8'h20, 8'd2, -1, 0, -1, 1'b1, 4, 1'b0};
        lit0 = '{8'h10, 8'hEF, 8'h11, 8'hEE, 8'h12, 8'hED};
        lit2 = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        lat0 = 0;

        for (int i = 0; i < 256; i++) rom_mem[i] = {8'(i), ~8'(i)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_msb", {a_busy, a_done, a_err, a_wr, a_xrst, a_dout, a_addr}, 0);
        chk("reset_outs_lsb", {b_busy, b_done, b_err, b_wr, b_xrst, b_dout, b_addr}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 7; r++) begin
            addr_before = a_addr;
            build_exp(vt[r].b, vt[r].n);
            run_load(vt[r].b, vt[r].n, vt[r].stall_at, vt[r].stall_len,
                     vt[r].ovf_at, vt[r].spur, 1'b0, lat);
            cmp_log($sformatf("row%0d_data_msb", r), 1'b0, vt[r].exp_wr);
            cmp_log($sformatf("row%0d_data_lsb", r), 1'b1, vt[r].exp_wr);
            chk($sformatf("row%0d_done_pulses", r), done_cnt, 1);
            chk($sformatf("row%0d_clr_cycles", r), clr_cnt, CLR);
            chk($sformatf("row%0d_error", r), {a_err, b_err}, {vt[r].exp_err, vt[r].exp_err});
            chk($sformatf("row%0d_wr_while_full", r), bad_full, 0);
            chk($sformatf("row%0d_desync", r), desync, 0);
            if (vt[r].exp_wr > 0 && vt[r].ovf_at < 0)
                chk($sformatf("row%0d_done_after_ack", r), done_cyc > last_ack_cyc, 1);
            if (r == 0) begin
                lat0 = lat;
                for (int i = 0; i < 6; i++)
                    chk($sformatf("spec_bytes_%0d", i), logA[i], lit0[i]);
            end
            if (r == 1) chk("stall_delay", lat, lat0 + 5);
            if (r == 2) begin
                chk("wrap_last_addr", a_addr, 8'h00);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("wrap_lsb_bytes_%0d", i), logB[i], lit2[i]);
            end
            if (r == 3) chk("n0_rom_addr_kept", a_addr, addr_before);
            if (r == 5) chk("word_period", lat, lat0 + 2 + LAT + LANES);
        end

        // Reset in the middle of a write burst
        logA.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        base_addr = 8'h30;
        n_words = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (logA.size() < 1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_wr_en", a_wr, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_msb", {a_busy, a_done, a_err, a_wr, a_xrst, a_dout, a_addr}, 0);
        chk("async_reset_lsb", {b_busy, b_done, b_err, b_wr, b_xrst, b_dout, b_addr}, 0);
        nw = logA.size();
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_no_done", done_cnt, 0);
        chk("reset_no_writes", logA.size(), nw);
        build_exp(8'h30, 8'd3);
        run_load(8'h30, 8'd3, -1, 0, -1, 1'b0, 1'b0, lat);
        cmp_log("post_reset_load", 1'b0, 6);
        chk("post_reset_done", done_cnt, 1);

        // Random ROM contents, random backpressure and ack delay
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
        for (int r = 0; r < 25; r++) begin
            ack_dly = $urandom_range(1, 3);
            b = 8'($urandom);
            n = $urandom_range(0, 6);
            build_exp(b, 8'(n));
            run_load(b, 8'(n), -1, 0, -1, 1'b0, 1'b1, lat);
            cmp_log($sformatf("rnd%0d_data_msb", r), 1'b0, n * LANES);
            cmp_log($sformatf("rnd%0d_data_lsb", r), 1'b1, n * LANES);
            chk($sformatf("rnd%0d_done_pulses", r), done_cnt, 1);
            chk($sformatf("rnd%0d_clr_cycles", r), clr_cnt, CLR);
            chk($sformatf("rnd%0d_error", r), a_err, 0);
            chk($sformatf("rnd%0d_wr_while_full", r), bad_full, 0);
            if (n > 0)
                chk($sformatf("rnd%0d_done_after_ack", r), done_cyc > last_ack_cyc, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
